pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Replaces the constant IF/ID, ID/EX, EX/MEM and MEM/WB register enables with generated stage enables, bubble and flush controls.
- Sequences pipeline fill after reset, load-use stalls, taken-branch/jump redirects and data-memory wait freezes.
- Sits beside the Control unit; drives the PC register and all four pipeline registers.

Parameters:
- PC_W, 5, PC width in instruction slots (32 instructions).
- FILL_CYCLES, 4, cycles after reset before hazard logic is armed.
- FLUSH_CYCLES, 1, cycles the redirect/flush condition is held after a taken branch.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in IF/ID (bits 25:21).
- id_rt  in  5  rt field of the instruction in IF/ID (bits 20:16).
- id_uses_rt  in  1  decoded instruction reads rt (R-type, store, branch).
- ex_memread  in  1  MemRead control bit of the ID/EX instruction.
- ex_rt  in  5  rt destination of the ID/EX instruction.
- mem_branch  in  1  Muxif control bit of the EX/MEM instruction.
- mem_zero  in  1  zero flag latched in EX/MEM.
- mem_target  in  PC_W  branch/jump target latched in EX/MEM.
- mem_wait  in  1  data memory not ready; freeze the whole pipe.
- pc_en  out  1  PC register load enable.
- pc_sel  out  1  1 selects pc_target, 0 selects PC+1.
- pc_target  out  PC_W  redirect address.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register enables.
- if_id_flush  out  1  load NOP (all-zero) into IF/ID.
- id_ex_bubble  out  1  zero the 11-bit control field entering ID/EX.
- ex_mem_flush  out  1  zero the control field entering EX/MEM.
- state_o  out  2  current state, for debug.

Behaviour:
- States: FILL=0, RUN=1, STALL=2, FLUSH=3. The state and the counter cnt (width clog2 of max(FILL_CYCLES, FLUSH_CYCLES)+1) are registered. All outputs are combinational from state, cnt and the inputs.
- Reset (clk edge with reset=1): state=FILL, cnt=0, pc_target register=0.
  - While reset is high: pc_en=0, all stage enables=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=0, pc_sel=0.
  - Reset asserted mid-stall or mid-flush aborts the operation identically.
- FILL:
  - pc_en=1, all enables=1, no flush or bubble, pc_sel=0. Hazard inputs are ignored.
  - cnt increments each cycle; at cnt==FILL_CYCLES-1 the next state is RUN and cnt clears.
  - mem_wait is still honoured (see freeze).
- Load-use hazard: hz = ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- RUN priority, highest first: branch, freeze, hazard.
  - Branch: mem_branch && mem_zero.
    - Same cycle: pc_sel=1, pc_target=mem_target, pc_en=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1.
    - Next state FLUSH with cnt=0; mem_target is captured into the pc_target register.
  - Freeze: mem_wait=1. pc_en and all four enables are 0; state is unchanged.
  - Hazard: hz=1. pc_en=0, if_id_en=0, id_ex_bubble=1, other enables=1. Next state STALL.
  - Otherwise: everything enabled, no flush.
- STALL:
  - Exactly one bubble cycle per load-use hazard.
  - In STALL: pc_en=1, all enables=1, no bubble. Next state RUN.
  - Branch detected in STALL is handled as in RUN (it takes priority).
- FLUSH:
  - pc_sel=0, pc_en=1, if_id_flush=1, id_ex_bubble=1. cnt increments.
  - At cnt==FLUSH_CYCLES-1 the next state is RUN.
  - A new branch in FLUSH is ignored (its instruction has already been squashed).
- Freeze (mem_wait=1) in any non-reset state holds state and cnt, and forces pc_en and all enables to 0.
  - Exception: a branch in RUN/STALL still redirects, but only on the first cycle with mem_wait=0.
- Register $0: ex_rt==0 never stalls.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt (16), flush_cnt (16) and freeze_cnt (16).
  - Counters increment on each STALL entry, FLUSH entry and frozen cycle respectively.
  - Counters saturate at 0xFFFF and clear on reset.
- Undefined: these ports and their logic are absent.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (FILL/RUN/STALL/FLUSH, 2 bits),
  - the NOP instruction constant 32'h0,
  - CTRL_W=11,
  - REG_ADDR_W=5.
- One combinational sub-module, load_use_detect, computes hz from id_rs, id_rt, id_uses_rt, ex_memread and ex_rt.

Test Plan:
- Reset for 2 cycles, release → state_o=FILL for 4 cycles, then RUN; pc_en=1 throughout; no flush after cycle 0.
- RUN, ex_memread=1, ex_rt=8, id_rs=8 → pc_en=0, if_id_en=0, id_ex_bubble=1 for exactly 1 cycle, then RUN with all enables=1.
- Same as previous but ex_rt=0, or id_rt=8 with id_uses_rt=0 and id_rs=3 → no stall.
- RUN, mem_branch=1, mem_zero=1, mem_target=17 → same cycle pc_sel=1, pc_target=17, all three flushes=1; next cycle FLUSH; then RUN.
- RUN with a load-use hazard and a taken branch in the same cycle → branch wins: no STALL entry, state goes to FLUSH.
- mem_wait=1 for 3 cycles during STALL → all enables=0, state stays STALL; after release, 1 cycle of STALL then RUN. With HAZARD_PERF_CNT_EN: freeze_cnt=3, stall_cnt=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the 5-stage MIPS pipeline control logic.
//   ctrl_state_e : controller state encoding (FILL/RUN/STALL/FLUSH)
//   NOP_INSTR    : all-zero instruction loaded into IF/ID on a flush
//   CTRL_W       : width of the decoded control field carried in ID/EX
//   REG_ADDR_W   : register file address width
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int CTRL_W     = 11;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_FLUSH = 2'd3
   } ctrl_state_e;

endpackage

// File: rtl/load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard detector.
//   id_rs, id_rt   in  source register fields of the instruction in IF/ID
//   id_uses_rt     in  instruction in IF/ID actually reads rt
//   ex_memread     in  instruction in ID/EX is a load
//   ex_rt          in  destination register of that load
//   hz             out load result is needed by the next instruction
// ---------------------------------------------------------------------------
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic                  ex_memread,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   output logic                  hz
);

   // A load into $0 never produces a usable value, so it can never cause a
   // stall. rt only matters when the decoded instruction really reads it,
   // otherwise an I-type destination field would stall for nothing.
   always_comb begin
      hz = ex_memread && (ex_rt != '0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush/freeze controller for the 5-stage MIPS pipeline.
// Generates the PC load enable, the PC redirect, the four pipeline register
// enables and the bubble/flush controls.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   id_rs, id_rt          source fields of the IF/ID instruction
//   id_uses_rt            IF/ID instruction reads rt
//   ex_memread, ex_rt     load indication and destination of ID/EX
//   mem_branch, mem_zero  taken-branch condition from EX/MEM
//   mem_target            branch/jump target from EX/MEM
//   mem_wait              data memory busy, freeze the pipe
//   pc_en, pc_sel         PC load enable and redirect select
//   pc_target             redirect address
//   if_id_en .. mem_wb_en stage register enables
//   if_id_flush           load NOP into IF/ID
//   id_ex_bubble          zero the control field entering ID/EX
//   ex_mem_flush          zero the control field entering EX/MEM
//   state_o               current controller state (debug)
//
// Optional build macro HAZARD_PERF_CNT_EN adds saturating 16-bit counters
// stall_cnt, flush_cnt and freeze_cnt.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int PC_W         = 5,
   parameter int FILL_CYCLES  = 4,
   parameter int FLUSH_CYCLES = 1
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic                  ex_memread,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  mem_branch,
   input  logic                  mem_zero,
   input  logic [PC_W-1:0]       mem_target,
   input  logic                  mem_wait,
   output logic                  pc_en,
   output logic                  pc_sel,
   output logic [PC_W-1:0]       pc_target,
   output logic                  if_id_en,
   output logic                  id_ex_en,
   output logic                  ex_mem_en,
   output logic                  mem_wb_en,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  ex_mem_flush,
`ifdef HAZARD_PERF_CNT_EN
   output logic [15:0]           stall_cnt,
   output logic [15:0]           flush_cnt,
   output logic [15:0]           freeze_cnt,
`endif
   output logic [1:0]            state_o
);

   localparam int CNT_MAX = (FILL_CYCLES > FLUSH_CYCLES) ? FILL_CYCLES : FLUSH_CYCLES;
   localparam int CNT_W   = ($clog2(CNT_MAX + 1) < 1) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

   ctrl_state_e      state;
   ctrl_state_e      state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [PC_W-1:0]  target_q;
   logic [PC_W-1:0]  target_nxt;
   logic             hz;
   logic             take_branch;

   load_use_detect u_load_use_detect (
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .ex_memread (ex_memread),
      .ex_rt      (ex_rt),
      .hz         (hz)
   );

   // A taken branch is only acted on from RUN or STALL. In FLUSH the branch
   // instruction has itself been squashed, and during FILL the pipe holds no
   // real instructions yet. While memory is stalled the redirect is deferred
   // until the first cycle mem_wait drops, so the branch is not lost.
   always_comb begin
      take_branch = mem_branch && mem_zero && !mem_wait &&
                    ((state == ST_RUN) || (state == ST_STALL));
   end

   // Output and next-state decode. Priority is reset, then branch redirect,
   // then memory freeze, then per-state behaviour. Reset holds the PC and
   // fills the front of the pipe with NOPs so nothing spurious retires.
   always_comb begin
      pc_en        = 1'b1;
      pc_sel       = 1'b0;
      pc_target    = target_q;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_flush = 1'b0;
      state_nxt    = state;
      cnt_nxt      = cnt;
      target_nxt   = target_q;

      if (reset) begin
         pc_en        = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (take_branch) begin
         pc_sel       = 1'b1;
         pc_target    = mem_target;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         ex_mem_flush = 1'b1;
         state_nxt    = ST_FLUSH;
         cnt_nxt      = '0;
         target_nxt   = mem_target;
      end else if (mem_wait) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
      end else begin
         case (state)
            ST_FILL: begin
               if (cnt == FILL_LAST) begin
                  state_nxt = ST_RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (hz) begin
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_bubble = 1'b1;
                  state_nxt    = ST_STALL;
               end
            end
            ST_STALL: begin
               state_nxt = ST_RUN;
            end
            ST_FLUSH: begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               if (cnt == FLUSH_LAST) begin
                  state_nxt = ST_RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_nxt = ST_FILL;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // State, counter and captured redirect target. Reset is synchronous and
   // aborts any stall or flush in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_FILL;
         cnt      <= '0;
         target_q <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         target_q <= target_nxt;
      end
   end

   assign state_o = state;

`ifdef HAZARD_PERF_CNT_EN
   logic stall_inc;
   logic flush_inc;
   logic freeze_inc;

   // Event strobes: a stall entry is a RUN-to-STALL transition, a flush
   // entry is every accepted redirect, a frozen cycle is any non-reset
   // cycle with memory busy.
   always_comb begin
      stall_inc  = !reset && (state != ST_STALL) && (state_nxt == ST_STALL);
      flush_inc  = !reset && take_branch;
      freeze_inc = !reset && mem_wait;
   end

   // Saturating event counters so a long run never wraps to a small value.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         freeze_cnt <= '0;
      end else begin
         if (stall_inc && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
         if (flush_inc && (flush_cnt != 16'hFFFF)) begin
            flush_cnt <= flush_cnt + 16'd1;
         end
         if (freeze_inc && (freeze_cnt != 16'hFFFF)) begin
            freeze_cnt <= freeze_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed testbench for pipeline_hazard_ctrl: reset, fill sequence,
// load-use stalls, $0 and unused-rt cases, branch redirect and flush,
// branch-versus-hazard priority, memory freeze during STALL and RUN, and
// reset in the middle of a flush. With HAZARD_PERF_CNT_EN defined the
// performance counters are checked too.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   localparam int PC_W = 5;

   logic            clk;
   logic            reset;
   logic [4:0]      id_rs;
   logic [4:0]      id_rt;
   logic            id_uses_rt;
   logic            ex_memread;
   logic [4:0]      ex_rt;
   logic            mem_branch;
   logic            mem_zero;
   logic [PC_W-1:0] mem_target;
   logic            mem_wait;
   logic            pc_en;
   logic            pc_sel;
   logic [PC_W-1:0] pc_target;
   logic            if_id_en;
   logic            id_ex_en;
   logic            ex_mem_en;
   logic            mem_wb_en;
   logic            if_id_flush;
   logic            id_ex_bubble;
   logic            ex_mem_flush;
   logic [1:0]      state_o;
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0]     stall_cnt;
   logic [15:0]     flush_cnt;
   logic [15:0]     freeze_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   pipeline_hazard_ctrl #(
      .PC_W         (PC_W),
      .FILL_CYCLES  (4),
      .FLUSH_CYCLES (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .ex_memread   (ex_memread),
      .ex_rt        (ex_rt),
      .mem_branch   (mem_branch),
      .mem_zero     (mem_zero),
      .mem_target   (mem_target),
      .mem_wait     (mem_wait),
      .pc_en        (pc_en),
      .pc_sel       (pc_sel),
      .pc_target    (pc_target),
      .if_id_en     (if_id_en),
      .id_ex_en     (id_ex_en),
      .ex_mem_en    (ex_mem_en),
      .mem_wb_en    (mem_wb_en),
      .if_id_flush  (if_id_flush),
      .id_ex_bubble (id_ex_bubble),
      .ex_mem_flush (ex_mem_flush),
`ifdef HAZARD_PERF_CNT_EN
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt),
      .freeze_cnt   (freeze_cnt),
`endif
      .state_o      (state_o)
   );

   // 10 time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends even if the sequence stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Sets the load-use related inputs in one call.
   task automatic applyStimulus(input logic memread, input logic [4:0] ert,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic uses_rt);
      ex_memread = memread;
      ex_rt      = ert;
      id_rs      = rs;
      id_rt      = rt;
      id_uses_rt = uses_rt;
      #1;
   endtask

   // Advances one clock and samples 1 time unit after the edge.
   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [3:0] enables();
      return {if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
   endfunction

   function automatic logic [2:0] flushes();
      return {if_id_flush, id_ex_bubble, ex_mem_flush};
   endfunction

   initial begin
      reset      = 1'b1;
      id_rs      = '0;
      id_rt      = '0;
      id_uses_rt = 1'b0;
      ex_memread = 1'b0;
      ex_rt      = '0;
      mem_branch = 1'b0;
      mem_zero   = 1'b0;
      mem_target = '0;
      mem_wait   = 1'b0;

      // Reset held for two cycles.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_state", 32'(state_o), 32'd0);
      checkOutput("rst_pc_en", 32'(pc_en), 32'd0);
      checkOutput("rst_pc_sel", 32'(pc_sel), 32'd0);
      checkOutput("rst_pc_target", 32'(pc_target), 32'd0);
      checkOutput("rst_enables", 32'(enables()), 32'hF);
      checkOutput("rst_flushes", 32'(flushes()), 32'b110);

      // Fill: four FILL cycles with pc_en=1, hazard inputs ignored.
      reset = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) applyStimulus(1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
         if (i == 2) applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
         checkOutput($sformatf("fill_state_%0d", i), 32'(state_o), 32'd0);
         checkOutput($sformatf("fill_pc_en_%0d", i), 32'(pc_en), 32'd1);
         checkOutput($sformatf("fill_flushes_%0d", i), 32'(flushes()), 32'd0);
         checkOutput($sformatf("fill_enables_%0d", i), 32'(enables()), 32'hF);
         stepClock();
      end
      checkOutput("run_state", 32'(state_o), 32'd1);
      checkOutput("run_pc_en", 32'(pc_en), 32'd1);
      checkOutput("run_enables", 32'(enables()), 32'hF);

      // Load-use hazard on rs: one bubble cycle then back to RUN.
      applyStimulus(1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
      checkOutput("lu_pc_en", 32'(pc_en), 32'd0);
      checkOutput("lu_enables", 32'(enables()), 32'h7);
      checkOutput("lu_flushes", 32'(flushes()), 32'b010);
      stepClock();
      checkOutput("lu_stall_state", 32'(state_o), 32'd2);
      checkOutput("lu_stall_pc_en", 32'(pc_en), 32'd1);
      checkOutput("lu_stall_enables", 32'(enables()), 32'hF);
      checkOutput("lu_stall_bubble", 32'(id_ex_bubble), 32'd0);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      stepClock();
      checkOutput("lu_back_state", 32'(state_o), 32'd1);
      checkOutput("lu_back_enables", 32'(enables()), 32'hF);

      // No stall: load into $0, and rt match when rt is not read.
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
      checkOutput("r0_pc_en", 32'(pc_en), 32'd1);
      checkOutput("r0_bubble", 32'(id_ex_bubble), 32'd0);
      applyStimulus(1'b1, 5'd8, 5'd3, 5'd8, 1'b0);
      checkOutput("rt_unused_pc_en", 32'(pc_en), 32'd1);
      checkOutput("rt_unused_enables", 32'(enables()), 32'hF);
      stepClock();
      checkOutput("rt_unused_state", 32'(state_o), 32'd1);

      // Same rt match but rt is read: stall.
      applyStimulus(1'b1, 5'd8, 5'd3, 5'd8, 1'b1);
      checkOutput("rt_used_pc_en", 32'(pc_en), 32'd0);
      checkOutput("rt_used_if_id_en", 32'(if_id_en), 32'd0);
      stepClock();
      checkOutput("rt_used_state", 32'(state_o), 32'd2);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      stepClock();
      checkOutput("rt_used_back", 32'(state_o), 32'd1);

      // Not-taken branch: mem_zero low.
      mem_branch = 1'b1;
      mem_zero   = 1'b0;
      mem_target = 5'd17;
      #1;
      checkOutput("bnt_pc_sel", 32'(pc_sel), 32'd0);
      checkOutput("bnt_flushes", 32'(flushes()), 32'd0);

      // Taken branch to 17.
      mem_zero = 1'b1;
      #1;
      checkOutput("br_pc_sel", 32'(pc_sel), 32'd1);
      checkOutput("br_pc_target", 32'(pc_target), 32'd17);
      checkOutput("br_pc_en", 32'(pc_en), 32'd1);
      checkOutput("br_flushes", 32'(flushes()), 32'b111);
      stepClock();
      mem_target = 5'd5;
      #1;
      checkOutput("fl_state", 32'(state_o), 32'd3);
      checkOutput("fl_pc_sel_ignored", 32'(pc_sel), 32'd0);
      checkOutput("fl_pc_target_reg", 32'(pc_target), 32'd17);
      checkOutput("fl_pc_en", 32'(pc_en), 32'd1);
      checkOutput("fl_flushes", 32'(flushes()), 32'b110);
      mem_branch = 1'b0;
      mem_zero   = 1'b0;
      stepClock();
      checkOutput("fl_back_state", 32'(state_o), 32'd1);

      // Hazard and taken branch together: branch wins.
      applyStimulus(1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
      mem_branch = 1'b1;
      mem_zero   = 1'b1;
      mem_target = 5'd9;
      #1;
      checkOutput("bh_pc_sel", 32'(pc_sel), 32'd1);
      checkOutput("bh_pc_en", 32'(pc_en), 32'd1);
      checkOutput("bh_if_id_en", 32'(if_id_en), 32'd1);
      checkOutput("bh_pc_target", 32'(pc_target), 32'd9);
      stepClock();
      checkOutput("bh_state", 32'(state_o), 32'd3);
      mem_branch = 1'b0;
      mem_zero   = 1'b0;
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      stepClock();
      checkOutput("bh_back_state", 32'(state_o), 32'd1);

      // Freeze for three cycles while in STALL.
      applyStimulus(1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
      stepClock();
      checkOutput("fz_enter_stall", 32'(state_o), 32'd2);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      mem_wait = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("fz_state_%0d", i), 32'(state_o), 32'd2);
         checkOutput($sformatf("fz_pc_en_%0d", i), 32'(pc_en), 32'd0);
         checkOutput($sformatf("fz_enables_%0d", i), 32'(enables()), 32'd0);
         stepClock();
      end
      mem_wait = 1'b0;
      #1;
      checkOutput("fz_rel_state", 32'(state_o), 32'd2);
      checkOutput("fz_rel_pc_en", 32'(pc_en), 32'd1);
      checkOutput("fz_rel_enables", 32'(enables()), 32'hF);
      stepClock();
      checkOutput("fz_back_state", 32'(state_o), 32'd1);

      // Branch during freeze in RUN is deferred to the first free cycle.
      mem_wait   = 1'b1;
      mem_branch = 1'b1;
      mem_zero   = 1'b1;
      mem_target = 5'd21;
      #1;
      checkOutput("bf_pc_sel", 32'(pc_sel), 32'd0);
      checkOutput("bf_pc_en", 32'(pc_en), 32'd0);
      stepClock();
      checkOutput("bf_state", 32'(state_o), 32'd1);
      mem_wait = 1'b0;
      #1;
      checkOutput("bf_rel_pc_sel", 32'(pc_sel), 32'd1);
      checkOutput("bf_rel_pc_target", 32'(pc_target), 32'd21);
      stepClock();
      checkOutput("bf_flush_state", 32'(state_o), 32'd3);
      mem_branch = 1'b0;
      mem_zero   = 1'b0;
      stepClock();
      checkOutput("bf_back_state", 32'(state_o), 32'd1);

`ifdef HAZARD_PERF_CNT_EN
      checkOutput("perf_stall_cnt", 32'(stall_cnt), 32'd3);
      checkOutput("perf_flush_cnt", 32'(flush_cnt), 32'd3);
      checkOutput("perf_freeze_cnt", 32'(freeze_cnt), 32'd4);
`endif

      // Reset in the middle of a flush aborts it.
      mem_branch = 1'b1;
      mem_zero   = 1'b1;
      mem_target = 5'd4;
      stepClock();
      checkOutput("rf_state", 32'(state_o), 32'd3);
      mem_branch = 1'b0;
      mem_zero   = 1'b0;
      reset      = 1'b1;
      #1;
      checkOutput("rf_pc_en", 32'(pc_en), 32'd0);
      checkOutput("rf_flushes", 32'(flushes()), 32'b110);
      checkOutput("rf_pc_sel", 32'(pc_sel), 32'd0);
      stepClock();
      checkOutput("rf_reset_state", 32'(state_o), 32'd0);
      checkOutput("rf_pc_target", 32'(pc_target), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
      checkOutput("rf_perf_clear", 32'({stall_cnt, flush_cnt} | 32'(freeze_cnt)), 32'd0);
`endif
      reset = 1'b0;
      #1;
      checkOutput("rf_fill_pc_en", 32'(pc_en), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
